// File: rtl/mold_msg_fifo.sv
// rtl/mold_msg_fifo.sv - whole-message elastic FIFO between MoldUDP64 extractor and ITCH decoder
module mold_msg_fifo #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = 8,
  parameter int ML_W       = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  mold_msg_v_i,
  input  logic                  mold_msg_start_i,
  input  logic [ML_W-1:0]       mold_msg_len_i,
  input  logic [AXI_KEEP_W-1:0] mold_msg_mask_i,
  input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
  output logic                  itch_msg_v_o,
  input  logic                  itch_msg_ready_i,
  output logic                  itch_msg_start_o,
  output logic                  itch_msg_last_o,
  output logic [ML_W-1:0]       itch_msg_len_o,
  output logic [AXI_KEEP_W-1:0] itch_msg_mask_o,
  output logic [AXI_DATA_W-1:0] itch_msg_data_o,
  output logic [CNT_W-1:0]      drop_cnt_o,
  output logic                  err_proto_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int KS = $clog2(AXI_KEEP_W);
  localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_e;

  state_e          state_q, state_d;
  logic [ML_W-1:0] rem_q, rem_d;
  logic [ML_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] drop_cnt_q;
  logic            err_q;

  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     occ_q;
  logic [PW:0]     free;

  logic [ML_W-1:0] len_sum, beats_raw, beats;
  logic            fits;
  logic            wr_en, wr_start, wr_last;
  logic            drop_hit, proto_hit, pop;

  logic [AXI_DATA_W-1:0] mem_data  [DEPTH];
  logic [AXI_KEEP_W-1:0] mem_mask  [DEPTH];
  logic [ML_W-1:0]       mem_len   [DEPTH];
  logic                  mem_start [DEPTH];
  logic                  mem_last  [DEPTH];

  // Beat count is rounded up in ML_W bits; a zero result still occupies one beat
  assign len_sum   = mold_msg_len_i + ML_W'(AXI_KEEP_W - 1);
  assign beats_raw = len_sum >> KS;
  assign beats     = (beats_raw == '0) ? ML_W'(1) : beats_raw;
  assign free      = FULL_OCC - occ_q;
  assign fits      = (32'(beats) <= 32'(free));
  assign pop       = itch_msg_v_o & itch_msg_ready_i;

  // Per-beat decode: decide write/drop/error and the next message-tracking state
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    len_d     = len_q;
    wr_en     = 1'b0;
    wr_start  = 1'b0;
    drop_hit  = 1'b0;
    proto_hit = 1'b0;
    if (mold_msg_v_i) begin
      if (mold_msg_start_i) begin
        // A start while a message is open means the previous one was truncated
        proto_hit = (state_q != S_IDLE);
        len_d     = mold_msg_len_i;
        rem_d     = beats - ML_W'(1);
        if (fits) begin
          wr_en    = 1'b1;
          wr_start = 1'b1;
          state_d  = (rem_d == '0) ? S_IDLE : S_WRITE;
        end else begin
          drop_hit = 1'b1;
          state_d  = (rem_d == '0) ? S_IDLE : S_DROP;
        end
      end else begin
        case (state_q)
          S_WRITE: begin
            wr_en   = 1'b1;
            rem_d   = rem_q - ML_W'(1);
            state_d = (rem_d == '0) ? S_IDLE : S_WRITE;
          end
          S_DROP: begin
            rem_d   = rem_q - ML_W'(1);
            state_d = (rem_d == '0) ? S_IDLE : S_DROP;
          end
          default: proto_hit = 1'b1;
        endcase
      end
    end
  end

  assign wr_last = (rem_d == '0);

  // Write FSM state, latched length, saturating drop counter and sticky error
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      len_q      <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      if (drop_hit && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
      if (proto_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  // Entry storage; contents are meaningless until occupancy covers them
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q]  <= mold_msg_data_i;
      mem_mask[wr_ptr_q]  <= mold_msg_mask_i;
      mem_len[wr_ptr_q]   <= len_d;
      mem_start[wr_ptr_q] <= wr_start;
      mem_last[wr_ptr_q]  <= wr_last;
    end
  end

  // Pointers wrap naturally; occupancy tracks +write -pop
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_en, pop})
        2'b10:   occ_q <= occ_q + (PW+1)'(1);
        2'b01:   occ_q <= occ_q - (PW+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign itch_msg_v_o     = (occ_q != '0);
  assign itch_msg_start_o = mem_start[rd_ptr_q];
  assign itch_msg_last_o  = mem_last[rd_ptr_q];
  assign itch_msg_len_o   = mem_len[rd_ptr_q];
  assign itch_msg_mask_o  = mem_mask[rd_ptr_q];
  assign itch_msg_data_o  = mem_data[rd_ptr_q];
  assign drop_cnt_o       = drop_cnt_q;
  assign err_proto_o      = err_q;

`ifndef SYNTHESIS
  // Start-of-message reservation must make a write into a full FIFO impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!nreset)
                                  !(wr_en && (occ_q == FULL_OCC)));
`endif

endmodule

// File: tb/tb_mold_msg_fifo.sv
// tb/tb_mold_msg_fifo.sv - randomized bench for mold_msg_fifo against a message-level queue model
module tb_mold_msg_fifo;

  logic        clk = 1'b0;
  logic        nreset;
  logic        v_i, start_i, ready;
  logic [15:0] len_i;
  logic [7:0]  mask_i;
  logic [63:0] data_i;
  logic        v_o, start_o, last_o;
  logic [15:0] len_o;
  logic [7:0]  mask_o;
  logic [63:0] data_o;
  logic [15:0] drop_cnt;
  logic        err_proto;

  always #5 clk = ~clk;

  mold_msg_fifo dut (
    .clk              (clk),
    .nreset           (nreset),
    .mold_msg_v_i     (v_i),
    .mold_msg_start_i (start_i),
    .mold_msg_len_i   (len_i),
    .mold_msg_mask_i  (mask_i),
    .mold_msg_data_i  (data_i),
    .itch_msg_v_o     (v_o),
    .itch_msg_ready_i (ready),
    .itch_msg_start_o (start_o),
    .itch_msg_last_o  (last_o),
    .itch_msg_len_o   (len_o),
    .itch_msg_mask_o  (mask_o),
    .itch_msg_data_o  (data_o),
    .drop_cnt_o       (drop_cnt),
    .err_proto_o      (err_proto)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  mask;
    logic [15:0] len;
    logic        start;
    logic        last;
  } ent_t;

  ent_t        q[$];
  int          m_mode;   // 0 no open message, 1 accepting, 2 discarding
  int          m_rem;
  logic [15:0] m_len;
  int          m_drop;
  bit          m_err;
  int          ready_mode;
  int          vecs = 0;
  int          errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input logic [15:0] len);
    logic [15:0] s;
    int b;
    s = len + 16'd7;
    b = int'(s) / 8;
    return (b == 0) ? 1 : b;
  endfunction

  task automatic model_beat();
    int b;
    ent_t e;
    if (!v_i) return;
    e.data = data_i;
    e.mask = mask_i;
    if (start_i) begin
      if (m_mode != 0) m_err = 1'b1;
      b      = beats_of(len_i);
      m_len  = len_i;
      m_rem  = b - 1;
      if (b <= 16 - q.size()) begin
        e.len = len_i; e.start = 1'b1; e.last = (b == 1);
        q.push_back(e);
        m_mode = (b > 1) ? 1 : 0;
      end else begin
        if (m_drop < 65535) m_drop++;
        m_mode = (b > 1) ? 2 : 0;
      end
    end else if (m_mode == 0) begin
      m_err = 1'b1;
    end else begin
      m_rem--;
      if (m_mode == 1) begin
        e.len = m_len; e.start = 1'b0; e.last = (m_rem == 0);
        q.push_back(e);
      end
      if (m_rem == 0) m_mode = 0;
    end
  endtask

  task automatic step();
    bit do_pop;
    if (ready_mode == 1)      ready = ~ready;
    else if (ready_mode == 2) ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("v", 64'(v_o), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("start", 64'(start_o), 64'(q[0].start));
      chk("last",  64'(last_o),  64'(q[0].last));
      chk("len",   64'(len_o),   64'(q[0].len));
      chk("mask",  64'(mask_o),  64'(q[0].mask));
      chk("data",  data_o,       q[0].data);
    end
    chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
    chk("err_proto", 64'(err_proto), 64'(m_err));
    do_pop = (q.size() != 0) && ready;
    model_beat();
    if (do_pop) void'(q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit v, input bit s, input logic [15:0] len);
    v_i     = v;
    start_i = s;
    len_i   = s ? len : 16'($urandom);
    mask_i  = 8'($urandom);
    data_i  = {$urandom, $urandom};
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 16'd0);
  endtask

  task automatic send_msg(input logic [15:0] len);
    int b;
    b = beats_of(len);
    for (int i = 0; i < b; i++) beat(1'b1, i == 0, len);
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    v_i = 1'b0; start_i = 1'b0;
    q.delete();
    m_mode = 0; m_rem = 0; m_drop = 0; m_err = 1'b0;
    #2;
    chk("rst_v",    64'(v_o),       64'(0));
    chk("rst_drop", 64'(drop_cnt),  64'(0));
    chk("rst_err",  64'(err_proto), 64'(0));
    @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  initial begin
    nreset = 1'b0;
    v_i = 1'b0; start_i = 1'b0; len_i = '0; mask_i = '0; data_i = '0;
    ready = 1'b1; ready_mode = 0;
    m_mode = 0; m_rem = 0; m_len = '0; m_drop = 0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    idle(2);

    // single 3-beat message with ready held high
    send_msg(16'd20);
    idle(4);
    chk("t1_drop", 64'(drop_cnt), 64'(0));

    // zero-length message is one beat with start and last
    send_msg(16'd0);
    idle(3);

    // fill 15 of 16 entries, then a 2-beat message must be dropped
    ready = 1'b0;
    for (int i = 0; i < 5; i++) send_msg(16'd24);
    send_msg(16'd16);
    idle(1);
    chk("t2_drop", 64'(drop_cnt), 64'(1));
    ready = 1'b1;
    idle(18);
    chk("t2_empty", 64'(v_o), 64'(0));

    // message longer than the whole FIFO, then a small one
    send_msg(16'd200);
    send_msg(16'd8);
    idle(3);
    chk("t3_drop", 64'(drop_cnt), 64'(2));

    // reset mid-message, stream resumes with an orphan beat
    beat(1'b1, 1'b1, 16'd40);
    beat(1'b1, 1'b0, 16'd0);
    do_reset();
    beat(1'b1, 1'b0, 16'd0);
    idle(2);
    chk("t4_err", 64'(err_proto), 64'(1));
    chk("t4_v",   64'(v_o),       64'(0));

    // burst with ready toggling every cycle, crossing pointer wrap
    ready_mode = 1;
    for (int i = 0; i < 10; i++) send_msg(16'($urandom_range(1, 48)));
    idle(40);

    // random stream including truncations, gaps and wrapping lengths
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        beat(1'b0, 1'b0, 16'd0);
      else if ($urandom_range(0, 4) == 0)
        beat(1'b1, 1'b1, ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'($urandom_range(0, 150)));
      else
        beat(1'b1, 1'b0, 16'd0);
    end
    ready_mode = 0;
    ready = 1'b1;
    idle(40);
    chk("final_empty", 64'(v_o), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mold_msg_fifo.md
# mold_msg_fifo

Elastic buffer between the MoldUDP64 message extractor and the downstream ITCH decoder. It accepts the extractor's unthrottled per-beat message stream and stores whole messages in a DEPTH-entry FIFO. It presents them on a valid/ready interface with start and last markers. A message that cannot fit entirely in free space when its first beat arrives is dropped as a whole and counted. Partial messages are never written.

## Interface
- AXI_DATA_W, 64: message data beat width in bits.
- AXI_KEEP_W, 8: byte mask width (AXI_DATA_W/8, power of 2).
- ML_W, 16: message length field width (bytes).
- DEPTH, 16: FIFO entries, power of 2, at least 2.
- CNT_W, 16: drop counter width.

- clk  in  1  clock.
- nreset  in  1  reset, asynchronous, active-low.
- mold_msg_v_i  in  1  beat valid; no backpressure.
- mold_msg_start_i  in  1  first beat of a message.
- mold_msg_len_i  in  ML_W  message length in bytes; sampled only when start is set.
- mold_msg_mask_i  in  AXI_KEEP_W  byte valid mask.
- mold_msg_data_i  in  AXI_DATA_W  message bytes.
- itch_msg_v_o  out  1  output beat valid.
- itch_msg_ready_i  in  1  consumer ready.
- itch_msg_start_o  out  1  first beat of the message.
- itch_msg_last_o  out  1  final beat of the message.
- itch_msg_len_o  out  ML_W  message length, repeated on every beat.
- itch_msg_mask_o  out  AXI_KEEP_W  byte mask.
- itch_msg_data_o  out  AXI_DATA_W  data.
- drop_cnt_o  out  CNT_W  dropped messages, saturating.
- err_proto_o  out  1  sticky protocol error flag.

## Operation
- Beats needed per message: beats = (len + AXI_KEEP_W-1) >> log2(AXI_KEEP_W), computed in ML_W bits. A length of 0 counts as 1 beat.
- free = DEPTH - occ_q, where occ_q is the registered occupancy. A pop in the same cycle does not count toward free space.
- Write FSM has three states: IDLE, WRITE, DROP.
  - From IDLE, on v and start: if beats <= free, write the beat and load rem = beats-1. Go to WRITE, or stay in IDLE if rem is 0. If beats > free, discard the beat, increment drop_cnt, and go to DROP (or stay in IDLE if beats is 1).
  - In IDLE, v without start: discard the beat and set err_proto.
  - In WRITE, on v without start: write the beat and decrement rem. Return to IDLE when rem reaches 0.
  - In DROP, on v without start: discard the beat and decrement rem. Return to IDLE when rem reaches 0.
  - In WRITE or DROP, v with start (the previous message was truncated): set err_proto, then evaluate the beat as a new message start, as in IDLE. Entries already written for the truncated message stay in the FIFO without last set.
- Each stored entry holds {data, mask, len, start, last}. last = (rem_next == 0) on the written beat. len is latched at start and stored on every beat.
- Reservation at start guarantees no overflow. A write when occ_q == DEPTH is illegal and is covered by an assertion.
- Read side: pop = itch_msg_v_o & itch_msg_ready_i. All outputs hold stable while v & ~ready.
- Pointers have log2(DEPTH) bits and wrap naturally. occ_q has log2(DEPTH)+1 bits and is updated by +write, -pop; a simultaneous write and pop leaves it unchanged.
- drop_cnt saturates at 2^CNT_W-1. err_proto clears only on reset.

## Timing
- Reset values: itch_msg_v_o=0, drop_cnt_o=0, err_proto_o=0, FSM=IDLE, rem=0, pointers=0, occ_q=0. Data, mask and len outputs are don't-care while v is low.
- Reset asserted mid-message flushes the FIFO and the FSM. A stream resuming mid-message after reset is handled as orphan beats.
- Write-to-output latency: a beat written at edge N is visible on itch_msg_v_o after edge N, with no bypass path. An empty FIFO shows v=0 in the write cycle.
- Throughput: 1 write plus 1 pop per cycle is sustained. Full and empty are both handled correctly when write and pop coincide.
- Drop decision and counter increment happen in the start-beat cycle; drop_cnt_o is updated at the next edge.

## Test plan
- Single 20-byte message, 3 beats, ready held at 1 -> 3 output beats with start on beat 0, last on beat 2, len=20 on all beats, masks passed through; drop_cnt=0.
- DEPTH=16, ready=0, five 24-byte messages (15 beats) followed by a 16-byte message -> the sixth message is dropped and drop_cnt=1. Releasing ready drains exactly 15 beats, with 5 starts and 5 lasts.
- Message longer than DEPTH beats (len=200, 25 beats) into an empty FIFO -> all 25 beats discarded, drop_cnt=1, FSM back in IDLE. A following 8-byte message is accepted.
- Beat with v=1 and start=0 immediately after reset -> discarded, err_proto_o=1, itch_msg_v_o stays 0.
- ready toggling every cycle during a 10-message burst with occupancy crossing the pointer wrap -> beat order and content match, outputs stable while stalled, occ never exceeds 16.
- len=0 start beat -> one output beat with start=1, last=1, len=0.
